mips_writeback: RTL and testbench

Register-file write-back stage for the MIPS core. It accepts R-type ALU results tagged with their destination register and queues them in a small FIFO. It drains the FIFO into the register file's write port over a strobe/acknowledge handshake. It also exposes a forwarding lookup, so the operand-read path can observe results that are still queued.

---
 rtl/mips_writeback.sv | 154 +++++++++++++++
 tb/tb_mips_writeback.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_writeback.sv
`default_nettype none
// ============================================================================
// Module      : mips_writeback
// Description : Register-file write-back stage. Queues tagged R-type ALU
//               results in a small FIFO and drains them to the register file
//               over a strobe/acknowledge handshake. A combinational lookup
//               lets the operand-read path see results that are still queued.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              in_rd,
    input  logic [5:0]              in_funct,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    rf_write,
    output logic [4:0]              rf_addr,
    output logic [DATA_W-1:0]       rf_data,
    input  logic                    rf_ack,
    input  logic [4:0]              lookup_addr,
    output logic                    lookup_hit,
    output logic [DATA_W-1:0]       lookup_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [5:0]    c_funct_jr = 6'h08;
    localparam logic [CW-1:0] c_full     = CW'(DEPTH);

    // Drain state encoding
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_issue = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [4:0]        r_mem_rd   [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];

    logic              w_full;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count_nxt;
    logic [AW-1:0]     w_idx;

    // Handshake and FIFO bookkeeping. Writes to r0 and jr results are
    // accepted but dropped, since they never update the register file.
    assign w_full      = (r_count == c_full);
    assign in_ready    = !w_full && !reset;
    assign w_accept    = in_valid && in_ready;
    assign w_push      = w_accept && (in_rd != 5'd0) && (in_funct != c_funct_jr);
    assign w_pop       = (r_state == c_st_issue) && rf_ack;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign count       = r_count;

    // Drain state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain next-state: issue as soon as anything is queued, go idle once
    // the last entry has been acknowledged.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_count_nxt != '0) begin
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue: begin
                if (w_pop && (w_count_nxt == '0)) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Register-file write port driven from the head entry while issuing;
    // held at zero when idle so the bus is quiet.
    always_comb begin
        rf_write = 1'b0;
        rf_addr  = '0;
        rf_data  = '0;
        if (r_state == c_st_issue) begin
            rf_write = 1'b1;
            rf_addr  = r_mem_rd[r_rd_ptr];
            rf_data  = r_mem_data[r_rd_ptr];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // FIFO storage: {rd, data} written at the tail
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_rd[i]   <= '0;
                r_mem_data[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= in_rd;
            r_mem_data[r_wr_ptr] <= in_data;
        end
    end

    // Forwarding lookup: walk live entries oldest to newest so the last
    // match (the newest value) wins. r0 never forwards.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        w_idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + AW'(k);
            if ((CW'(k) < r_count) && (lookup_addr != 5'd0) &&
                (r_mem_rd[w_idx] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = r_mem_data[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_writeback
// Description : Self-checking bench for mips_writeback. A queue-based model
//               of pending register writes predicts every output each cycle;
//               directed steps are followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_writeback;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [4:0]             in_rd;
    logic [5:0]             in_funct;
    logic [DATA_W-1:0]      in_data;
    logic                   rf_write;
    logic [4:0]             rf_addr;
    logic [DATA_W-1:0]      rf_data;
    logic                   rf_ack;
    logic [4:0]             lookup_addr;
    logic                   lookup_hit;
    logic [DATA_W-1:0]      lookup_data;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    mips_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_funct    (in_funct),
        .in_data     (in_data),
        .rf_write    (rf_write),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data),
        .rf_ack      (rf_ack),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .count       (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the pending-write queue implies.
    task automatic check_all();
        logic        hit;
        logic [31:0] ld;
        hit = 1'b0;
        ld  = '0;
        if (lookup_addr != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].rd == lookup_addr) begin
                    hit = 1'b1;
                    ld  = q[i].data;
                end
            end
        end
        chk("count",       64'(count),       64'(q.size()));
        chk("in_ready",    64'(in_ready),    64'(!reset && (q.size() < DEPTH)));
        chk("rf_write",    64'(rf_write),    64'(q.size() != 0));
        chk("rf_addr",     64'(rf_addr),     (q.size() != 0) ? 64'(q[0].rd)   : 64'd0);
        chk("rf_data",     64'(rf_data),     (q.size() != 0) ? 64'(q[0].data) : 64'd0);
        chk("lookup_hit",  64'(lookup_hit),  64'(hit));
        chk("lookup_data", 64'(lookup_data), 64'(ld));
    endtask

    // One clock cycle: check, then advance the model with the sampled inputs.
    task automatic cyc();
        logic acc;
        logic pop;
        logic [5:0] fn;
        ent_t e;
        ent_t drop;
        #2;
        check_all();
        acc    = in_valid && !reset && (q.size() < DEPTH);
        pop    = rf_ack && (q.size() != 0);
        fn     = in_funct;
        e.rd   = in_rd;
        e.data = in_data;
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (pop) drop = q.pop_front();
            if (acc && (e.rd != 5'd0) && (fn != 6'h08)) q.push_back(e);
        end
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        in_valid = 1'b1;
        in_rd    = rd;
        in_funct = 6'h20;
        in_data  = data;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_funct = '0;
        in_data = '0; rf_ack = 1'b0; lookup_addr = '0;
        @(posedge clk); #1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Single push, held write, then ack
        push(5'd8, 32'h0000_0011);
        chk("t1_write", 64'(rf_write), 64'd1);
        chk("t1_addr",  64'(rf_addr),  64'd8);
        for (int i = 0; i < 3; i++) cyc();
        chk("t1_hold",  64'(rf_data),  64'h11);
        rf_ack = 1'b1;
        cyc();
        rf_ack = 1'b0;
        chk("t1_empty", 64'(count), 64'd0);
        chk("t1_idle",  64'(rf_write), 64'd0);

        // Filtered transfers
        in_valid = 1'b1; in_rd = 5'd0; in_funct = 6'h20; in_data = 32'hDEAD;
        cyc();
        in_rd = 5'd9; in_funct = 6'h08;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("t2_count", 64'(count), 64'd0);
        chk("t2_write", 64'(rf_write), 64'd0);

        // Fill, refuse fifth, drain back-to-back
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 16));
        #1;
        chk("t3_full", 64'(in_ready), 64'd0);
        push(5'd5, 32'h55);
        chk("t3_count", 64'(count), 64'd4);
        rf_ack = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_order", 64'(rf_addr), 64'(i));
            cyc();
        end
        rf_ack = 1'b0;
        chk("t3_idle", 64'(rf_write), 64'd0);

        // Forwarding of duplicate destinations
        push(5'd5, 32'hA);
        push(5'd5, 32'hB);
        lookup_addr = 5'd0; #1;
        chk("t4_zero_hit", 64'(lookup_hit), 64'd0);
        lookup_addr = 5'd5; #1;
        chk("t4_hit",  64'(lookup_hit),  64'd1);
        chk("t4_data", 64'(lookup_data), 64'hB);
        rf_ack = 1'b1; cyc(); rf_ack = 1'b0;
        chk("t4_data1", 64'(lookup_data), 64'hB);
        rf_ack = 1'b1; cyc(); rf_ack = 1'b0;
        chk("t4_miss",  64'(lookup_hit),  64'd0);
        chk("t4_miss_d", 64'(lookup_data), 64'd0);

        // Simultaneous push and pop at count 2
        push(5'd10, 32'h100);
        push(5'd11, 32'h101);
        rf_ack = 1'b1;
        push(5'd12, 32'h102);
        chk("t5_count", 64'(count), 64'd2);
        chk("t5_head",  64'(rf_addr), 64'd11);
        cyc();
        chk("t5_next",  64'(rf_addr), 64'd12);
        cyc();
        rf_ack = 1'b0;

        // Reset with queued entries
        push(5'd1, 32'h1); push(5'd2, 32'h2); push(5'd3, 32'h3);
        reset = 1'b1; #1;
        chk("t6_ready_rst", 64'(in_ready), 64'd0);
        cyc();
        reset = 1'b0; #1;
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_write", 64'(rf_write), 64'd0);
        chk("t6_ready", 64'(in_ready), 64'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_valid    = ($urandom_range(0, 9) < 6);
            in_rd       = 5'($urandom_range(0, 7));
            in_funct    = ($urandom_range(0, 7) == 0) ? 6'h08 : 6'($urandom);
            in_data     = $urandom;
            rf_ack      = 1'($urandom);
            lookup_addr = 5'($urandom_range(0, 7));
            reset       = ($urandom_range(0, 63) == 0);
            cyc();
        end
        reset = 1'b0; in_valid = 1'b0; rf_ack = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
